// File: rtl/rand_cmd_sel_pkg.sv
// rand_cmd_sel_pkg: shared states, default sizing and fallback helper for rand_cmd_sel
package rand_cmd_sel_pkg;

    typedef enum logic [1:0] {IDLE, FILL, CHECK, HOLD} state_t;

    localparam int CMD_W_DEF     = 2;
    localparam int NUM_CMDS_DEF  = 3;
    localparam int MAX_RETRY_DEF = 7;

    // Next command after last, wrapping num_cmds-1 back to 0; 0 when nothing was issued yet
    function automatic int next_cmd(input int last, input logic has_last, input int num_cmds);
        return has_last ? ((last >= num_cmds - 1) ? 0 : last + 1) : 0;
    endfunction

endpackage

// File: rtl/rand_bit_collector.sv
// rand_bit_collector: shifts CMD_W registered random bits into a candidate, pulsing done on the last one
module rand_bit_collector #(
    parameter int CMD_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             rand_bit,
    output logic [CMD_W-1:0] cand,
    output logic             done
);
    localparam int CNT_W = $clog2(CMD_W + 1);

    logic             en_d;
    logic [CNT_W-1:0] cnt;
    logic             cap;

    // A bit is only valid one cycle after enable, and only while still enabled
    assign cap  = en && en_d;
    assign done = cap && (cnt == CNT_W'(CMD_W - 1));

    // Enable delay, bit counter (cleared whenever disabled) and candidate shift register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_d <= 1'b0;
            cnt  <= '0;
            cand <= '0;
        end else begin
            en_d <= en;
            if (!en) cnt <= '0;
            else if (cap) begin
                cand <= CMD_W'({cand, rand_bit});
                cnt  <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/rand_cmd_sel.sv
// rand_cmd_sel: rejection-samples LFSR bits into a uniform command index; RAND_CMD_SEL_NO_REPEAT_EN also rejects repeats
module rand_cmd_sel
    import rand_cmd_sel_pkg::*;
#(
    parameter int CMD_W     = CMD_W_DEF,
    parameter int NUM_CMDS  = NUM_CMDS_DEF,
    parameter int MAX_RETRY = MAX_RETRY_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_req,
    input  logic             i_rand,
    input  logic             i_ack,
    output logic             o_rng_en,
    output logic [CMD_W-1:0] o_cmd,
    output logic             o_vld,
    output logic             o_fallback
);
    localparam int RW = $clog2(MAX_RETRY + 2);

    state_t           state, state_nx;
    logic [RW-1:0]    retry;
    logic [CMD_W-1:0] last_cmd, cand, fb_cmd, sel_cmd;
    logic             has_last, done, accept, exhausted;

    assign o_rng_en  = (state == FILL);
    assign o_vld     = (state == HOLD);
    assign exhausted = retry >= RW'(MAX_RETRY);
    assign fb_cmd    = CMD_W'(next_cmd(int'(last_cmd), has_last, NUM_CMDS));
    assign sel_cmd   = accept ? cand : fb_cmd;

`ifdef RAND_CMD_SEL_NO_REPEAT_EN
    assign accept = (int'(cand) < NUM_CMDS) && !(has_last && cand == last_cmd);
`else
    assign accept = int'(cand) < NUM_CMDS;
`endif

    rand_bit_collector #(.CMD_W(CMD_W)) u_collector (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (o_rng_en),
        .rand_bit (i_rand),
        .cand     (cand),
        .done     (done)
    );

    // Next-state: a rejection loops back to FILL until retries run out, then HOLD takes the fallback
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (i_req) state_nx = FILL;
            FILL:  if (done) state_nx = CHECK;
            CHECK: state_nx = (accept || exhausted) ? HOLD : FILL;
            HOLD:  if (i_ack) state_nx = IDLE;
        endcase
    end

    // State register, retry counter, output latch and command history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            retry      <= '0;
            o_cmd      <= '0;
            o_fallback <= 1'b0;
            last_cmd   <= '0;
            has_last   <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && i_req) retry <= '0;
            if (state == CHECK) begin
                if (accept || exhausted) begin
                    o_cmd      <= sel_cmd;
                    o_fallback <= !accept;
                    last_cmd   <= sel_cmd;
                    has_last   <= 1'b1;
                end else retry <= retry + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_rand_cmd_sel.sv
// tb_rand_cmd_sel: scoreboard bench for rand_cmd_sel against a per-attempt reference model
module tb_rand_cmd_sel;
    localparam int CMD_W     = 2;
    localparam int NUM_CMDS  = 3;
    localparam int MAX_RETRY = 7;
    localparam int BPA       = CMD_W + 1;
    localparam int ACYC      = CMD_W + 2;
    localparam int NBITS     = (MAX_RETRY + 1) * BPA;
`ifdef RAND_CMD_SEL_NO_REPEAT_EN
    localparam bit NOREP = 1'b1;
`else
    localparam bit NOREP = 1'b0;
`endif

    logic clk = 1'b0, rst_n = 1'b0, i_req = 1'b0, i_rand = 1'b0, i_ack = 1'b0;
    logic o_rng_en, o_vld, o_fallback;
    logic [CMD_W-1:0] o_cmd;

    rand_cmd_sel #(.CMD_W(CMD_W), .NUM_CMDS(NUM_CMDS), .MAX_RETRY(MAX_RETRY)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_req      (i_req),
        .i_rand     (i_rand),
        .i_ack      (i_ack),
        .o_rng_en   (o_rng_en),
        .o_cmd      (o_cmd),
        .o_vld      (o_vld),
        .o_fallback (o_fallback)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cmd;
        bit fb;
        int lat;
        int en_cyc;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    bit   gen_q[$];
    int   checks = 0, passed = 0;
    int   cyc = 0, start_cyc = 0, en_cnt = 0, held = 0;
    bit   last_vld = 1'b0, en_s = 1'b0;
    int   m_last = 0;
    bit   m_has = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act == req) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, req);
    endtask

    // Each attempt consumes BPA generated bits: the first CMD_W form the candidate MSB-first, the last is wasted
    function automatic exp_t model(input logic [NBITS-1:0] bs);
        exp_t e;
        int cand;
        for (int k = 0; k <= MAX_RETRY; k++) begin
            cand = 0;
            for (int j = 0; j < CMD_W; j++) cand = cand * 2 + int'(bs[k*BPA+j]);
            if (cand < NUM_CMDS && !(NOREP && m_has && cand == m_last)) begin
                e.cmd = cand; e.fb = 1'b0; e.lat = (k + 1) * ACYC; e.en_cyc = (k + 1) * BPA;
                return e;
            end
        end
        e.cmd = m_has ? (m_last + 1) % NUM_CMDS : 0;
        e.fb = 1'b1; e.lat = (MAX_RETRY + 1) * ACYC; e.en_cyc = (MAX_RETRY + 1) * BPA;
        return e;
    endfunction

    // Random-bit generator: a fresh registered bit one cycle after enable was seen high
    initial forever begin
        @(negedge clk);
        en_s = o_rng_en;
        @(posedge clk);
        #1;
        if (en_s) i_rand = (gen_q.size() > 0) ? gen_q.pop_front() : 1'($urandom_range(0, 1));
    end

    // Monitor: on each rising valid, pop the expected response; while valid, the command must hold
    initial forever begin
        @(negedge clk);
        if (!rst_n) last_vld = 1'b0;
        else begin
            if (o_rng_en) en_cnt++;
            if (o_vld && !last_vld) begin
                if (sbq.size() == 0) check("unexpected_vld", 1, 0);
                else begin
                    mon_e = sbq.pop_front();
                    check("cmd", int'(o_cmd), mon_e.cmd);
                    check("fallback", int'(o_fallback), int'(mon_e.fb));
                    check("latency", cyc - start_cyc, mon_e.lat);
                    check("rng_en_cycles", en_cnt, mon_e.en_cyc);
                    held = mon_e.cmd;
                end
            end else if (o_vld) check("cmd_stable", int'(o_cmd), held);
            last_vld = o_vld;
        end
    end

    task automatic idle_ack();
        @(negedge clk);
        i_ack = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_ack_vld", int'(o_vld), 0);
        check("idle_ack_rng_en", int'(o_rng_en), 0);
        i_ack = 1'b0;
    endtask

    task automatic do_req(input bit rnd, input logic [NBITS-1:0] pat, input bit hold_req);
        logic [NBITS-1:0] bs;
        exp_t e;
        int t;
        for (int i = 0; i < NBITS; i++) bs[i] = rnd ? 1'($urandom_range(0, 1)) : pat[NBITS-1-i];
        e = model(bs);
        m_last = e.cmd;
        m_has = 1'b1;
        gen_q.delete();
        for (int i = 0; i < NBITS; i++) gen_q.push_back(bs[i]);
        @(negedge clk);
        i_req = 1'b1;
        @(posedge clk);
        #1;
        start_cyc = cyc;
        en_cnt = 0;
        sbq.push_back(e);
        if (!hold_req) i_req = 1'b0;
        t = 0;
        while (!o_vld && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!o_vld) check("vld_timeout", 0, 1);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        i_ack = 1'b1;
        @(negedge clk);
        check("ack_drop", int'(o_vld), 0);
        i_ack = 1'b0;
        i_req = 1'b0;
        @(negedge clk);
        check("no_refill", int'(o_rng_en), 0);
        gen_q.delete();
    endtask

    task automatic reset_mid_fill();
        @(negedge clk);
        i_req = 1'b1;
        @(posedge clk);
        #1;
        i_req = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_rng_en", int'(o_rng_en), 0);
        check("rst_vld", int'(o_vld), 0);
        check("rst_cmd", int'(o_cmd), 0);
        check("rst_fallback", int'(o_fallback), 0);
        sbq.delete();
        gen_q.delete();
        m_has = 1'b0;
        m_last = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset_rng_en", int'(o_rng_en), 0);
        check("reset_vld", int'(o_vld), 0);
        check("reset_fallback", int'(o_fallback), 0);
        check("reset_cmd", int'(o_cmd), 0);
        rst_n = 1'b1;
        idle_ack();
        do_req(1'b0, {NBITS{1'b1}}, 1'b0);
        do_req(1'b0, {NBITS{1'b1}}, 1'b0);
        do_req(1'b0, {6'b110100, {(NBITS-6){1'b0}}}, 1'b0);
        do_req(1'b0, {6'b100010, {(NBITS-6){1'b0}}}, 1'b0);
        do_req(1'b0, {NBITS{1'b0}}, 1'b1);
        reset_mid_fill();
        do_req(1'b0, {NBITS{1'b1}}, 1'b0);
        do_req(1'b0, {NBITS{1'b0}}, 1'b0);
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) idle_ack();
            do_req(1'b1, '0, 1'($urandom_range(0, 1)));
        end
        repeat (3) @(negedge clk);
        check("sb_empty", sbq.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
